// File: rtl/bsg_downstream_token_out.sv
// bsg_downstream_token_out
// Receiver end of the off-chip link. Pairs of deserialized half-words are
// assembled into full words (low half first). The words are buffered in a
// credit-sized FIFO and presented to the core with a valid/yumi handshake.
// Every 2^LG_CREDIT_DECIMATION dequeued words toggle token_clk_o, returning
// credits to the upstream sender.
//
// Ports:
//   clk                 io-side clock, posedge
//   rst_n               async active-low reset
//   half_valid_i        a deserialized half-word is present this cycle
//   half_data_i         half-word; the first of a pair is the low half
//   core_valid_o        FIFO head is valid
//   core_data_o         FIFO head, first-word-fall-through
//   core_yumi_i         core consumes the head this cycle
//   token_clk_o         credit token, toggles once per decimation group
//   credits_returned_o  running count of credited words, wraps
//   overflow_o          sticky: a word arrived while the FIFO had no space
module bsg_downstream_token_out #(
    parameter int unsigned WIDTH                = 64,
    parameter int unsigned LG_FIFO_DEPTH        = 5,
    parameter int unsigned LG_CREDIT_DECIMATION = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       half_valid_i,
    input  logic [WIDTH/2-1:0]         half_data_i,
    output logic                       core_valid_o,
    output logic [WIDTH-1:0]           core_data_o,
    input  logic                       core_yumi_i,
    output logic                       token_clk_o,
    output logic [LG_FIFO_DEPTH+1:0]   credits_returned_o,
    output logic                       overflow_o
);

    localparam int unsigned HALF_W    = WIDTH / 2;
    localparam int unsigned DEPTH     = 1 << LG_FIFO_DEPTH;
    localparam int unsigned PTR_W     = LG_FIFO_DEPTH + 1;
    localparam int unsigned CRED_W    = LG_FIFO_DEPTH + 2;
    localparam int unsigned DEC_W     = LG_CREDIT_DECIMATION;
    localparam int unsigned DEC_GROUP = 1 << LG_CREDIT_DECIMATION;

    localparam logic [0:0] ST_LOW  = 1'b0;
    localparam logic [0:0] ST_HIGH = 1'b1;

    logic [0:0]        state_q,    state_d;
    logic [HALF_W-1:0] low_q,      low_d;
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic              core_valid_q, core_valid_d;
    logic [WIDTH-1:0]  core_data_q,  core_data_d;
    logic              token_q,    token_d;
    logic [CRED_W-1:0] credits_q,  credits_d;
    logic              overflow_q, overflow_d;
    logic [DEC_W-1:0]  dec_q,      dec_d;

    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              wr_req_c;
    logic              wr_accept_c;
    logic              deq_c;
    logic              full_c;
    logic [WIDTH-1:0]  word_c;

    // Full when the pointers differ only in their wrap bit.
    assign full_c = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                    (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);

    assign word_c      = {half_data_i, low_q};
    assign wr_req_c    = (state_q == ST_HIGH) && half_valid_i;
    // A yumi with nothing at the head is ignored.
    assign deq_c       = core_yumi_i && core_valid_q;
    // At full, a same-cycle dequeue frees the slot the write needs.
    assign wr_accept_c = wr_req_c && (!full_c || deq_c);

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOW;
            low_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            core_valid_q <= 1'b0;
            core_data_q  <= '0;
            token_q      <= 1'b0;
            credits_q    <= '0;
            overflow_q   <= 1'b0;
            dec_q        <= '0;
        end else begin
            state_q      <= state_d;
            low_q        <= low_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            core_valid_q <= core_valid_d;
            core_data_q  <= core_data_d;
            token_q      <= token_d;
            credits_q    <= credits_d;
            overflow_q   <= overflow_d;
            dec_q        <= dec_d;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_accept_c) begin
            mem_q[wr_ptr_q[PTR_W-2:0]] <= word_c;
        end
    end

    // Next-state: assembler, FIFO pointers, registered head and credit return.
    always_comb begin
        state_d      = state_q;
        low_d        = low_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        core_valid_d = core_valid_q;
        core_data_d  = core_data_q;
        token_d      = token_q;
        credits_d    = credits_q;
        overflow_d   = overflow_q;
        dec_d        = dec_q;

        case (state_q)
            ST_LOW: begin
                if (half_valid_i) begin
                    low_d   = half_data_i;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (half_valid_i) begin
                    state_d = ST_LOW;
                end
            end
            default: state_d = ST_LOW;
        endcase

        if (wr_req_c && !wr_accept_c) begin
            overflow_d = 1'b1;
        end

        if (wr_accept_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (deq_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            dec_d    = dec_q + DEC_W'(1);
            if (dec_d == '0) begin
                token_d   = ~token_q;
                credits_d = credits_q + CRED_W'(DEC_GROUP);
            end
        end

        // Head lookup for next cycle; a word written into the head slot
        // is not in the array yet, so take it straight from the assembler.
        core_valid_d = (rd_ptr_d != wr_ptr_d);
        if (!core_valid_d) begin
            core_data_d = '0;
        end else if (wr_accept_c &&
                     (wr_ptr_q[PTR_W-2:0] == rd_ptr_d[PTR_W-2:0])) begin
            core_data_d = word_c;
        end else begin
            core_data_d = mem_q[rd_ptr_d[PTR_W-2:0]];
        end
    end

    assign core_valid_o       = core_valid_q;
    assign core_data_o        = core_data_q;
    assign token_clk_o        = token_q;
    assign credits_returned_o = credits_q;
    assign overflow_o         = overflow_q;

endmodule
